// File: rtl/coded_converter_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// coded_converter_scheduler_pkg
// Shared definitions for the coded converter scheduler: datapath widths, the
// sequencing FSM state type and the one-hot encode / Gray / decode functions.
// The same functions are available to any model that needs the reference
// conversion.
// -----------------------------------------------------------------------------
package coded_converter_scheduler_pkg;

   localparam int DATA_W = 16;
   localparam int IDX_W  = 4;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ENC  = 2'd1,
      DEC  = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Index of the highest set bit; an all-zero word encodes to 0.
   function automatic logic [IDX_W-1:0] enc_bin(input logic [DATA_W-1:0] d);
      logic [IDX_W-1:0] b;
      b = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (d[i]) b = IDX_W'(i);
      end
      return b;
   endfunction

   // Flags a word that is zero or has more than one bit set.
   function automatic logic enc_err(input logic [DATA_W-1:0] d);
      return ($countones(d) != 1);
   endfunction

   function automatic logic [IDX_W-1:0] bin2gray(input logic [IDX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [DATA_W-1:0] dec_onehot(input logic [IDX_W-1:0] g);
      return DATA_W'(1) << g;
   endfunction

endpackage

// File: rtl/coded_converter_scheduler_if.sv
// -----------------------------------------------------------------------------
// coded_converter_scheduler_if
// Request / response bus of the coded converter scheduler.
//   req_valid  [NREQ]        per-requester request, held until accepted
//   req_data   [NREQ*16]     requester i word at [16*i +: 16]
//   req_ready  [NREQ]        grant, at most one bit high
//   rsp_valid / rsp_ready    response handshake
//   rsp_data   [16]          one-hot converted word
//   rsp_id     [IDW]         requester that issued the response
//   rsp_err                  source word was zero or not one-hot
//   busy                     scheduler not idle
//   done_count [16]          completed responses, wrapping
// master: requesters + consumer side.  slave: the scheduler.
// -----------------------------------------------------------------------------
interface coded_converter_scheduler_if
   import coded_converter_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) ();

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_W-1:0]      rsp_data;
   logic [IDW-1:0]         rsp_id;
   logic                   rsp_err;
   logic                   busy;
   logic [CNT_W-1:0]       done_count;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, done_count
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, done_count
   );

endinterface

// File: rtl/coded_converter_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// coded_converter_scheduler_rr_arbiter
// Purely combinational round-robin arbiter: grants the first asserted request
// at or above ptr, wrapping to index 0.
//   req       [NREQ]  request vector
//   ptr       [IDW]   highest-priority index for this cycle
//   grant     [NREQ]  one-hot grant (all zero when no request)
//   grant_idx [IDW]   index of the granted request
//   grant_any         a grant was issued
// -----------------------------------------------------------------------------
module coded_converter_scheduler_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   // Two passes: upper segment [ptr, NREQ-1] first, then the wrapped
   // segment [0, ptr-1]; the first hit blocks every later one.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!grant_any && req[j] && (j >= int'(ptr))) begin
            grant[j]  = 1'b1;
            grant_idx = IDW'(j);
            grant_any = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!grant_any && req[j] && (j < int'(ptr))) begin
            grant[j]  = 1'b1;
            grant_idx = IDW'(j);
            grant_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coded_converter_scheduler.sv
// -----------------------------------------------------------------------------
// coded_converter_scheduler
// Shares one encode -> binary-to-Gray -> decode path among NREQ requesters.
// A round-robin grant in IDLE captures one one-hot word, two registered
// stages convert it, and the result is held on the response port with the
// requester id until the consumer accepts it.
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    coded_converter_scheduler_if.slave (request/response bus, busy,
//          done_count)
// -----------------------------------------------------------------------------
module coded_converter_scheduler
   import coded_converter_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input logic                        clk,
   input logic                        rst_n,
   coded_converter_scheduler_if.slave bus
);

   state_t            state;
   state_t            state_nxt;
   logic [IDW-1:0]    rr_ptr;
   logic [NREQ-1:0]   arb_req;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    grant_idx;
   logic              grant_any;
   logic [DATA_W-1:0] sel_data;
   logic              busy;
   logic [CNT_W-1:0]  done_count;

   logic [DATA_W-1:0] data_p0;
   logic [IDW-1:0]    id_p0;
   logic [IDX_W-1:0]  gray_p1;
   logic              err_p1;
   logic [DATA_W-1:0] rsp_data_p2;
   logic [IDW-1:0]    rsp_id_p2;
   logic              rsp_err_p2;
   logic              vld_p2;

   coded_converter_scheduler_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .req       (arb_req),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_any) state_nxt = ENC;
         ENC:     state_nxt = DEC;
         DEC:     state_nxt = HOLD;
         HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic. Arbitration is masked while reset is asserted so that no
   // grant is shown for a request the reset would discard.
   always_comb begin
      arb_req = '0;
      if ((state == IDLE) && rst_n) arb_req = bus.req_valid;
      busy = (state != IDLE);
   end

   // Granted word select
   always_comb begin
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant[j]) sel_data = bus.req_data[j*DATA_W +: DATA_W];
      end
   end

   // Control: round-robin pointer, response valid, completion counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         vld_p2     <= 1'b0;
         done_count <= '0;
      end else begin
         if ((state == IDLE) && grant_any) begin
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (state == DEC) begin
            vld_p2 <= 1'b1;
         end else if ((state == HOLD) && bus.rsp_ready) begin
            vld_p2     <= 1'b0;
            done_count <= done_count + 1'b1;
         end
      end
   end

   // ---- Stage p0: capture granted word and id (IDLE) ----
   always_ff @(posedge clk) begin
      if ((state == IDLE) && grant_any) begin
         data_p0 <= sel_data;
         id_p0   <= grant_idx;
      end
   end

   // ---- Stage p1: encode to binary index, convert to Gray (ENC) ----
   always_ff @(posedge clk) begin
      if (state == ENC) begin
         gray_p1 <= bin2gray(enc_bin(data_p0));
         err_p1  <= enc_err(data_p0);
      end
   end

   // ---- Stage p2: decode Gray code to one-hot response (DEC) ----
   // Response registers are cleared by reset so the port shows zeros.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_data_p2 <= '0;
         rsp_id_p2   <= '0;
         rsp_err_p2  <= 1'b0;
      end else if (state == DEC) begin
         rsp_data_p2 <= dec_onehot(gray_p1);
         rsp_id_p2   <= id_p0;
         rsp_err_p2  <= err_p1;
      end
   end

   assign bus.req_ready  = grant;
   assign bus.rsp_valid  = vld_p2;
   assign bus.rsp_data   = rsp_data_p2;
   assign bus.rsp_id     = rsp_id_p2;
   assign bus.rsp_err    = rsp_err_p2;
   assign bus.busy       = busy;
   assign bus.done_count = done_count;

endmodule

// File: tb/tb_coded_converter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_coded_converter_scheduler
// Self-checking bench for coded_converter_scheduler. Accepted requests push
// their expected response onto a scoreboard queue; responses pop and compare.
// Directed sequences cover reset values, the conversion mapping, error words,
// round-robin order, back-pressure and reset in the middle of a conversion.
// -----------------------------------------------------------------------------
module tb_coded_converter_scheduler;
   import coded_converter_scheduler_pkg::*;

   localparam int NREQ = 4;

   typedef struct {
      logic [15:0] d;
      int          id;
      logic        err;
      int          t;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_done = 0;
   logic rsp_prev = 1'b0;

   exp_t exp_q[$];
   int   grant_log[$];

   coded_converter_scheduler_if #(.NREQ(NREQ)) bus ();

   coded_converter_scheduler #(.NREQ(NREQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [15:0] w;
      if (!rst_n) begin
         exp_q.delete();
         grant_log.delete();
         rsp_prev = 1'b0;
         exp_done = 0;
      end else begin
         chk("rdy_onehot", 32'($countones(bus.req_ready) <= 1), 1);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               w     = bus.req_data[i*16 +: 16];
               e.d   = dec_onehot(bin2gray(enc_bin(w)));
               e.id  = i;
               e.err = enc_err(w);
               e.t   = cyc;
               exp_q.push_back(e);
               grant_log.push_back(i);
            end
         end
         if (bus.rsp_valid && !rsp_prev) begin
            if (exp_q.size() == 0) chk("rsp_spurious", exp_q.size(), 1);
            else                   chk("latency", cyc - exp_q[0].t, 3);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_data", bus.rsp_data, e.d);
               chk("sb_id", bus.rsp_id, e.id);
               chk("sb_err", bus.rsp_err, e.err);
            end
            chk("sb_count", bus.done_count, exp_done);
            exp_done++;
         end
         rsp_prev = bus.rsp_valid;
      end
   end

   task automatic accept_drop(input int id);
      bit ok = 1'b0;
      for (int k = 0; k < 30 && !ok; k++) begin
         @(negedge clk);
         ok = bus.req_ready[id];
      end
      chk("accept", ok, 1);
      @(posedge clk); #1;
      bus.req_valid[id] = 1'b0;
   endtask

   task automatic do_req(input int id, input logic [15:0] d, input logic [15:0] exp_d,
                         input logic exp_e);
      bit ok = 1'b0;
      @(posedge clk); #1;
      bus.rsp_ready         = 1'b0;
      bus.req_data[id*16 +: 16] = d;
      bus.req_valid[id]     = 1'b1;
      accept_drop(id);
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = bus.rsp_valid;
      end
      chk("rsp_seen", ok, 1);
      chk("rsp_data", bus.rsp_data, exp_d);
      chk("rsp_id", bus.rsp_id, id);
      chk("rsp_err", bus.rsp_err, exp_e);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = !bus.busy && (bus.req_valid == '0) && (exp_q.size() == 0);
      end
      chk("drain", ok, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int          n;
      int          rr_exp[5];
      logic [3:0]  b;
      logic [3:0]  g;
      rr_exp = '{0, 1, 2, 3, 0};

      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_data", bus.rsp_data, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_err", bus.rsp_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_count", bus.done_count, 0);
      chk("rst_ready", bus.req_ready, 0);

      // Single request and named mapping points
      do_req(1, 16'h0008, 16'h0004, 1'b0);
      do_req(0, 16'h0001, 16'h0001, 1'b0);
      do_req(2, 16'h0004, 16'h0008, 1'b0);
      do_req(3, 16'h8000, 16'h0100, 1'b0);

      // Error words
      do_req(2, 16'h0000, 16'h0001, 1'b1);
      do_req(3, 16'h0024, 16'h0080, 1'b1);

      // Full one-hot sweep
      for (int i = 0; i < 16; i++) begin
         b = 4'(i);
         g = b ^ (b >> 1);
         do_req(i % NREQ, 16'(1) << i, 16'(1) << g, 1'b0);
      end
      chk("sweep_count", bus.done_count, 22);

      // Back-pressure: response held for 10 cycles with a competing request
      @(posedge clk); #1;
      bus.req_data[15:0] = 16'h0010;
      bus.req_valid[0]   = 1'b1;
      accept_drop(0);
      bus.req_data[31:16] = 16'h0002;
      bus.req_valid[1]    = 1'b1;
      n = 0;
      for (int k = 0; k < 20 && n == 0; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) n = 1;
      end
      chk("bp_seen", n, 1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid", bus.rsp_valid, 1);
         chk("bp_data", bus.rsp_data, 16'h0040);
         chk("bp_id", bus.rsp_id, 0);
         chk("bp_ready", bus.req_ready, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", bus.rsp_valid, 1);
      @(negedge clk);
      chk("bp_after_valid", bus.rsp_valid, 0);
      chk("bp_after_busy", bus.busy, 0);
      chk("bp_next_grant", bus.req_ready, 4'b0010);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      drain();
      bus.rsp_ready = 1'b0;

      // Round-robin from reset with all requesters valid
      do_reset();
      bus.req_data  = {16'h0010, 16'h0008, 16'h0004, 16'h0002};
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 60 && n < 5; k++) begin
         @(negedge clk);
         if (bus.rsp_valid && bus.rsp_ready) n++;
      end
      chk("rr_handshakes", n, 5);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
      chk("rr_count", bus.done_count, 5);
      chk("rr_grants", grant_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, rr_exp[i]);
      end

      // Reset during DEC
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_data[47:32] = 16'h0100;
      bus.req_valid[2]    = 1'b1;
      accept_drop(2);
      bus.req_data[31:16] = 16'h0001;
      bus.req_data[63:48] = 16'h0020;
      bus.req_valid       = 4'b1010;
      @(posedge clk); #1;
      chk("mid_busy", bus.busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_valid", bus.rsp_valid, 0);
      chk("mid_data", bus.rsp_data, 0);
      chk("mid_id", bus.rsp_id, 0);
      chk("mid_err", bus.rsp_err, 0);
      chk("mid_busy_rst", bus.busy, 0);
      chk("mid_count", bus.done_count, 0);
      chk("mid_ready_rst", bus.req_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_grant", bus.req_ready, 4'b0010);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      bus.rsp_ready    = 1'b1;
      accept_drop(3);
      drain();
      chk("mid_done", bus.done_count, 2);
      chk("mid_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
      chk("mid_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
